// File: rtl/c880_bist_pkg.sv
// Shared definitions for the c880 BIST blocks: FSM states, response width,
// default MISR polynomial/seed and the pattern counter width.
package c880_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          C880_RESP_W = 26;
  localparam logic [31:0] DEF_POLY    = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED    = 32'hFFFF_FFFF;
  localparam int          PAT_CNT_W   = 16;

endpackage

// File: rtl/misr_step.sv
// One MISR step: shift left, fold in the polynomial when the MSB falls out,
// then XOR in the zero-extended response word. Purely combinational.
module misr_step
  import c880_bist_pkg::*;
#(
  parameter int               SIG_W  = 32,
  parameter int               RESP_W = C880_RESP_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY
) (
  input  logic [SIG_W-1:0]  i_sig,
  input  logic [RESP_W-1:0] i_resp,
  output logic [SIG_W-1:0]  o_sig
);

  logic [SIG_W-1:0] w_resp_ext;

  always_comb begin
    w_resp_ext               = '0;
    w_resp_ext[RESP_W-1:0]   = i_resp;
    o_sig = {i_sig[SIG_W-2:0], 1'b0} ^ (i_sig[SIG_W-1] ? POLY : '0) ^ w_resp_ext;
  end

endmodule

// File: rtl/c880_resp_misr.sv
// Compacts c880 responses into a MISR signature over NUM_PAT patterns and
// compares the final signature with a golden value captured at start.
module c880_resp_misr
  import c880_bist_pkg::*;
#(
  parameter int               RESP_W  = C880_RESP_W,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter int               NUM_PAT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RESP_W-1:0]    resp_i,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  input  logic [SIG_W-1:0]     golden_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [PAT_CNT_W-1:0] pat_count,
  output logic [1:0]           o_dbg_state
);

  // Handshake: a response beat transfers on a rising edge where resp_valid
  // and resp_ready are both high; resp_ready is high exactly while in RUN.

  localparam logic [PAT_CNT_W-1:0] LAST_CNT = PAT_CNT_W'(NUM_PAT - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [SIG_W-1:0]       r_sig;
  logic [SIG_W-1:0]       w_sig_nxt;
  logic [SIG_W-1:0]       r_golden;
  logic [PAT_CNT_W-1:0]   r_cnt;
  logic                   r_pass;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_start;

  misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr_step (
    .i_sig  (r_sig),
    .i_resp (resp_i),
    .o_sig  (w_sig_nxt)
  );

  assign w_accept = (r_state == ST_RUN) && resp_valid;
  assign w_last   = w_accept && (r_cnt == LAST_CNT);
  assign w_start  = start && (r_state != ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (start)  w_state_nxt = ST_RUN;
      default:             w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Abort leaves signature and count frozen so the partial run can be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig    <= SEED;
      r_cnt    <= '0;
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else if (abort) begin
      r_pass   <= 1'b0;
    end else if (w_start) begin
      r_sig    <= SEED;
      r_cnt    <= '0;
      r_golden <= golden_sig;
      r_pass   <= 1'b0;
    end else if (w_accept) begin
      r_sig    <= w_sig_nxt;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_pass <= (w_sig_nxt == r_golden);
    end
  end

  assign resp_ready  = (r_state == ST_RUN);
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign pass        = r_pass;
  assign signature   = r_sig;
  assign pat_count   = r_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_c880_resp_misr.sv
// Bench for c880_resp_misr: four instances (different NUM_PAT/SEED) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_c880_resp_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam int          NP [4] = '{1, 1, 4, 1024};
  localparam logic [31:0] SD [4] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [25:0] resp_i = '0;
  logic        resp_valid = 1'b0;
  logic [31:0] golden_sig = '0;

  logic [3:0]  w_ready, w_busy, w_done, w_pass;
  logic [31:0] w_sig [4];
  logic [15:0] w_cnt [4];
  logic [1:0]  w_dbg [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    c880_resp_misr #(
      .NUM_PAT (NP[gi]),
      .SEED    (SD[gi])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .resp_i      (resp_i),
      .resp_valid  (resp_valid),
      .resp_ready  (w_ready[gi]),
      .golden_sig  (golden_sig),
      .busy        (w_busy[gi]),
      .done        (w_done[gi]),
      .pass        (w_pass[gi]),
      .signature   (w_sig[gi]),
      .pat_count   (w_cnt[gi]),
      .o_dbg_state (w_dbg[gi])
    );
  end

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [25:0] r);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {6'h0, r};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h at %0t", name, idx, got, exp, $time);
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 finished.
  int          m_mode [4];
  logic [31:0] m_sig  [4];
  logic [31:0] m_gold [4];
  int          m_cnt  [4];
  logic        m_pass [4];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_mode[i] <= 0; m_sig[i] <= SD[i]; m_cnt[i] <= 0; m_pass[i] <= 1'b0;
        m_gold[i] <= '0;
      end else if (abort) begin
        m_mode[i] <= 0; m_pass[i] <= 1'b0;
      end else if (m_mode[i] != 1 && start) begin
        m_mode[i] <= 1; m_sig[i] <= SD[i]; m_cnt[i] <= 0; m_gold[i] <= golden_sig;
        m_pass[i] <= 1'b0;
      end else if (m_mode[i] == 1 && resp_valid) begin
        m_sig[i] <= misr(m_sig[i], resp_i);
        m_cnt[i] <= m_cnt[i] + 1;
        if (m_cnt[i] + 1 == NP[i]) begin
          m_mode[i] <= 2;
          m_pass[i] <= (misr(m_sig[i], resp_i) == m_gold[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk("busy",  i, 32'(w_busy[i]),  32'(m_mode[i] == 1));
      chk("ready", i, 32'(w_ready[i]), 32'(m_mode[i] == 1));
      chk("done",  i, 32'(w_done[i]),  32'(m_mode[i] == 2));
      chk("sig",   i, w_sig[i], m_sig[i]);
      chk("cnt",   i, 32'(w_cnt[i]), 32'(m_cnt[i]));
      if (m_mode[i] != 1) chk("pass", i, 32'(w_pass[i]), 32'(m_pass[i]));
    end
  end

  task automatic drive(input logic s, input logic a, input logic v,
                       input logic [25:0] r, input logic [31:0] g);
    @(negedge clk); #1;
    start = s; abort = a; resp_valid = v; resp_i = r; golden_sig = g;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
  endtask

  logic [25:0] arr [4];
  logic [25:0] big [1024];
  logic [31:0] exp_sig;
  logic [3:0]  vpat;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_sig_seedF", 0, w_sig[0], 32'hFFFF_FFFF);
    chk("rst_sig_seed0", 1, w_sig[1], 32'h0);
    chk("rst_busy", 3, 32'(w_busy[3]), 32'h0);

    // Single pattern, default seed, zero response.
    drive(1, 0, 0, 26'h0, 32'hFB3EE249);
    drive(0, 0, 1, 26'h0, 32'hFB3EE249);
    chk("np1_sig", 0, w_sig[0], 32'hFB3EE249);
    chk("np1_cnt", 0, 32'(w_cnt[0]), 32'd1);
    chk("np1_done", 0, 32'(w_done[0]), 32'd1);
    chk("np1_pass", 0, 32'(w_pass[0]), 32'd1);

    // Single pattern, zero seed, all-ones response.
    drive(1, 0, 0, 26'h0, 32'h0);
    drive(0, 0, 1, 26'h3FFFFFF, 32'h0);
    chk("seed0_sig", 1, w_sig[1], 32'h03FFFFFF);
    chk("seed0_pass", 1, 32'(w_pass[1]), 32'd0);
    chk("seed0_done", 1, 32'(w_done[1]), 32'd1);

    // Stalled NUM_PAT=4 run: valid pattern 1,0,0,1,1,0,1.
    drive(0, 1, 0, 26'h0, 32'h0);
    drive(1, 0, 0, 26'h0, $urandom);
    exp_sig = SD[2];
    for (int k = 0; k < 7; k++) begin
      logic v;
      logic [25:0] r;
      v = (k == 0 || k == 3 || k == 4 || k == 6);
      r = 26'($urandom);
      if (v) exp_sig = misr(exp_sig, r);
      drive(0, 0, v, r, golden_sig);
    end
    chk("np4_cnt", 2, 32'(w_cnt[2]), 32'd4);
    chk("np4_sig", 2, w_sig[2], exp_sig);
    chk("np4_ready", 2, 32'(w_ready[2]), 32'd0);

    // Abort on the third beat.
    for (int k = 0; k < 4; k++) arr[k] = 26'($urandom);
    drive(1, 0, 0, 26'h0, $urandom);
    drive(0, 0, 1, arr[0], golden_sig);
    drive(0, 0, 1, arr[1], golden_sig);
    drive(0, 1, 1, arr[2], golden_sig);
    chk("abort_cnt", 2, 32'(w_cnt[2]), 32'd2);
    chk("abort_sig", 2, w_sig[2], misr(misr(32'hFFFF_FFFF, arr[0]), arr[1]));
    chk("abort_done", 2, 32'(w_done[2]), 32'd0);
    chk("abort_busy", 2, 32'(w_busy[2]), 32'd0);
    drive(1, 0, 0, 26'h0, $urandom);
    chk("restart_sig", 2, w_sig[2], 32'hFFFF_FFFF);
    chk("restart_cnt", 2, 32'(w_cnt[2]), 32'd0);

    // Start inside RUN is ignored; start inside DONE reloads.
    drive(0, 0, 1, 26'($urandom), golden_sig);
    drive(0, 0, 1, 26'($urandom), golden_sig);
    drive(1, 0, 0, 26'h0, $urandom);
    chk("run_start_cnt", 2, 32'(w_cnt[2]), 32'd2);
    drive(0, 0, 1, 26'($urandom), golden_sig);
    drive(0, 0, 1, 26'($urandom), golden_sig);
    chk("run_done", 2, 32'(w_done[2]), 32'd1);
    exp_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) exp_sig = misr(exp_sig, arr[k]);
    drive(1, 0, 0, 26'h0, exp_sig);
    chk("reload_cnt", 2, 32'(w_cnt[2]), 32'd0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, arr[k], golden_sig);
    chk("reload_sig", 2, w_sig[2], exp_sig);
    chk("reload_pass", 2, 32'(w_pass[2]), 32'd1);

    // Asynchronous reset in the middle of a 1024-pattern run.
    for (int k = 0; k < 1024; k++) big[k] = 26'($urandom);
    exp_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 1024; k++) exp_sig = misr(exp_sig, big[k]);
    drive(0, 1, 0, 26'h0, 32'h0);
    drive(1, 0, 0, 26'h0, exp_sig);
    for (int k = 0; k < 500; k++) drive(0, 0, 1, big[k], exp_sig);
    chk("mid_cnt", 3, 32'(w_cnt[3]), 32'd500);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sig", 3, w_sig[3], 32'hFFFF_FFFF);
    chk("arst_cnt", 3, 32'(w_cnt[3]), 32'd0);
    chk("arst_busy", 3, 32'(w_busy[3]), 32'd0);
    chk("arst_ready", 3, 32'(w_ready[3]), 32'd0);
    chk("arst_done", 3, 32'(w_done[3]), 32'd0);
    chk("arst_pass", 3, 32'(w_pass[3]), 32'd0);
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 26'h0, exp_sig);
    for (int k = 0; k < 1024; k++) drive(0, 0, 1, big[k], exp_sig);
    chk("full_sig", 3, w_sig[3], exp_sig);
    chk("full_done", 3, 32'(w_done[3]), 32'd1);
    chk("full_pass", 3, 32'(w_pass[3]), 32'd1);
    chk("full_cnt", 3, 32'(w_cnt[3]), 32'd1024);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      vpat = 4'($urandom_range(0, 9));
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, vpat < 4'd7,
            26'($urandom), $urandom);
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
